// File: rtl/ctrl_pkg.sv
// Shared encodings and types for the RV32I decode/control stage.
package ctrl_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operations (alu_src)
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;  // MUL..REMU follow in funct3 order

    // Immediate format; IMM_NONE means operand B comes from rs2
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Branch condition; BR_JUMP covers JAL/JALR (target from ALU)
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    // ALU operand A select
    localparam logic [1:0] AMUX_RS1  = 2'd0;
    localparam logic [1:0] AMUX_PC   = 2'd1;
    localparam logic [1:0] AMUX_ZERO = 2'd2;

    // Writeback source
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [4:0] alu_src;
        logic [2:0] imm_src;
        logic [2:0] branch_src;
        logic       mem_write;
        logic [1:0] alu_mux_src;
        logic [1:0] wb_src;
        logic       reg_write;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    typedef enum logic {IDLE, BUSY} state_t;

    // Base integer ALU op from funct3; alt selects SUB/SRA
    function automatic logic [4:0] alu_base_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) decoder: instruction -> control bundle, illegal flag, operand usage.
module ctrl_decode import ctrl_pkg::*; #(
    parameter bit EN_M_EXT = 1'b0
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output logic         illegal,
    output logic         uses_rs1,
    output logic         uses_rs2,
    output logic         is_muldiv
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Main + ALU decode; an illegal encoding keeps register indices but clears all control
    always_comb begin
        bundle     = BUBBLE;
        bundle.rd  = instr[11:7];
        bundle.rs1 = instr[19:15];
        bundle.rs2 = instr[24:20];
        illegal    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        is_muldiv  = 1'b0;
        case (opcode)
            OP_LUI: begin
                bundle.imm_src     = IMM_U;
                bundle.alu_mux_src = AMUX_ZERO;
                bundle.reg_write   = 1'b1;
            end
            OP_AUIPC: begin
                bundle.imm_src     = IMM_U;
                bundle.alu_mux_src = AMUX_PC;
                bundle.reg_write   = 1'b1;
            end
            OP_JAL: begin
                bundle.imm_src     = IMM_J;
                bundle.alu_mux_src = AMUX_PC;
                bundle.branch_src  = BR_JUMP;
                bundle.wb_src      = WB_PC4;
                bundle.reg_write   = 1'b1;
            end
            OP_JALR: begin
                illegal            = (f3 != 3'b000);
                bundle.imm_src     = IMM_I;
                bundle.branch_src  = BR_JUMP;
                bundle.wb_src      = WB_PC4;
                bundle.reg_write   = 1'b1;
                uses_rs1           = 1'b1;
            end
            OP_BRANCH: begin
                bundle.imm_src     = IMM_B;
                bundle.alu_mux_src = AMUX_PC;
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
                case (f3)
                    3'b000:  bundle.branch_src = BR_EQ;
                    3'b001:  bundle.branch_src = BR_NE;
                    3'b100:  bundle.branch_src = BR_LT;
                    3'b101:  bundle.branch_src = BR_GE;
                    3'b110:  bundle.branch_src = BR_LTU;
                    3'b111:  bundle.branch_src = BR_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                illegal          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                bundle.imm_src   = IMM_I;
                bundle.wb_src    = WB_MEM;
                bundle.reg_write = 1'b1;
                uses_rs1         = 1'b1;
            end
            OP_STORE: begin
                illegal          = (f3 > 3'b010);
                bundle.imm_src   = IMM_S;
                bundle.mem_write = 1'b1;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OP_IMM: begin
                bundle.imm_src   = IMM_I;
                bundle.reg_write = 1'b1;
                bundle.alu_src   = alu_base_op(f3, 1'b0);
                uses_rs1         = 1'b1;
                if (f3 == 3'b001 && f7 != F7_BASE)
                    illegal = 1'b1;
                if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)
                        bundle.alu_src = ALU_SRA;
                    else if (f7 != F7_BASE)
                        illegal = 1'b1;
                end
            end
            OP_REG: begin
                bundle.reg_write = 1'b1;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                if (f7 == F7_BASE)
                    bundle.alu_src = alu_base_op(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    bundle.alu_src = alu_base_op(f3, 1'b1);
                else if (EN_M_EXT && f7 == F7_MULDIV) begin
                    bundle.alu_src = ALU_MUL + {2'b00, f3};
                    is_muldiv      = 1'b1;
                end else
                    illegal = 1'b1;
            end
            OP_FENCE: ;  // single-issue in-order core: fence is a no-op here
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            bundle.alu_src     = '0;
            bundle.imm_src     = IMM_NONE;
            bundle.branch_src  = BR_NONE;
            bundle.mem_write   = 1'b0;
            bundle.alu_mux_src = AMUX_RS1;
            bundle.wb_src      = WB_ALU;
            bundle.reg_write   = 1'b0;
            uses_rs1           = 1'b0;
            uses_rs2           = 1'b0;
            is_muldiv          = 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered decode stage: handshake, load-use bubble, flush, stall hold, mul/div issue lock.
module pipelined_control_unit import ctrl_pkg::*; #(
    parameter bit EN_M_EXT      = 1'b0,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        ex_stall,
    output logic        out_valid,
    output logic [4:0]  alu_src,
    output logic [2:0]  imm_src,
    output logic [2:0]  branch_src,
    output logic        mem_write,
    output logic [1:0]  alu_mux_src,
    output logic [1:0]  wb_src,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        illegal
);

    // Counter holds at most MULDIV_CYCLES-1
    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    ctrl_bundle_t  dec_bundle;
    logic          dec_illegal, dec_rs1, dec_rs2, dec_muldiv;
    ctrl_bundle_t  out_q, out_d;
    logic          valid_q, valid_d, ill_q, ill_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hazard, accept;

    ctrl_decode #(.EN_M_EXT(EN_M_EXT)) u_decode (
        .instr     (instr),
        .bundle    (dec_bundle),
        .illegal   (dec_illegal),
        .uses_rs1  (dec_rs1),
        .uses_rs2  (dec_rs2),
        .is_muldiv (dec_muldiv)
    );

    // Load in the output register whose rd feeds the incoming instruction
    assign hazard = valid_q && (out_q.wb_src == WB_MEM) && (out_q.rd != 5'd0) &&
                    ((dec_rs1 && dec_bundle.rs1 == out_q.rd) ||
                     (dec_rs2 && dec_bundle.rs2 == out_q.rd));

    assign in_ready = !rst && !flush && !ex_stall && !hazard && (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Next-state: flush > stall hold > accept > bubble (with BUSY countdown)
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        ill_d   = ill_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            out_d   = BUBBLE;
            valid_d = 1'b0;
            ill_d   = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!ex_stall) begin
            if (accept) begin
                out_d   = dec_bundle;
                valid_d = 1'b1;
                ill_d   = dec_illegal;
                if (EN_M_EXT && dec_muldiv && (MULDIV_CYCLES > 1)) begin
                    state_d = BUSY;
                    cnt_d   = CW'(MULDIV_CYCLES - 1);
                end
            end else begin
                out_d   = BUBBLE;
                valid_d = 1'b0;
                ill_d   = 1'b0;
                if (state_q == BUSY) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        end
    end

    // Output bundle, valid and FSM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= BUBBLE;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign illegal     = ill_q;
    assign alu_src     = out_q.alu_src;
    assign imm_src     = out_q.imm_src;
    assign branch_src  = out_q.branch_src;
    assign mem_write   = out_q.mem_write;
    assign alu_mux_src = out_q.alu_mux_src;
    assign wb_src      = out_q.wb_src;
    assign reg_write   = out_q.reg_write;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;

endmodule
